// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encodings, parity
// codes, the fallback payload width and small decode helpers.
package uart_pkg;

    // One-hot FSM state encodings; the value is exported directly on State_o.
    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_START  = 6'b000010,
        ST_DATA   = 6'b000100,
        ST_PARITY = 6'b001000,
        ST_STOP   = 6'b010000,
        ST_BREAK  = 6'b100000
    } tx_state_t;

    // Parity-mode codes as presented on ParityMode_i.
    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_ODD   = 3'd1,
        PAR_EVEN  = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } parity_mode_t;

    // Payload width used whenever the requested width is out of range.
    localparam logic [3:0] DEFAULT_DATA_W = 4'd8;

    // Clamp a requested payload length to the legal 5..max_w window.
    function automatic logic [3:0] eff_data_bits(input logic [3:0] req, input int max_w);
        if (int'(req) < 5 || int'(req) > max_w) begin
            return DEFAULT_DATA_W;
        end
        return req;
    endfunction

    // Undefined parity codes (5..7) behave as "no parity".
    function automatic parity_mode_t norm_parity(input logic [2:0] mode);
        if (mode > 3'd4) begin
            return PAR_NONE;
        end
        return parity_mode_t'(mode);
    endfunction

endpackage

// File: rtl/uart_parity_acc.sv
// Running parity over the data bits of one frame; the mode selects how the
// accumulated XOR is turned into the transmitted parity bit.
module uart_parity_acc
    import uart_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         bit_in,
    input  parity_mode_t mode,
    output logic         parity
);

    logic acc_reg;

    // XOR accumulator, cleared at the start of every frame.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_reg <= 1'b0;
        end else if (en) begin
            acc_reg <= acc_reg ^ bit_in;
        end
    end

    // Map the accumulated XOR onto the selected parity flavour.
    always_comb begin
        parity = 1'b0;
        case (mode)
            PAR_EVEN:  parity = acc_reg;
            PAR_ODD:   parity = ~acc_reg;
            PAR_MARK:  parity = 1'b1;
            default:   parity = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pulls words from a FIFO with a one-cycle read
// latency and shifts out start, data, optional parity and stop bits, one
// bit per baud tick. Also supports holding the line in break while idle.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W_MAX = 9,
    parameter int STOP_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_BaudSig_i,
    input  logic                  p_TxEn_i,
    input  logic [3:0]            DataBits_i,
    input  logic [2:0]            ParityMode_i,
    input  logic                  TwoStop_i,
    input  logic                  p_BigEnd_i,
    input  logic                  p_Break_i,
    output logic                  n_FifoRe_o,
    input  logic [DATA_W_MAX-1:0] FifoData_i,
    input  logic                  p_FiFoEmpty_i,
    output logic                  SerialData_o,
    output logic [5:0]            State_o,
    output logic                  p_Busy_o,
    output logic                  p_Done_o
);

    tx_state_t             state_reg;
    logic                  line_reg;
    logic                  re_n_reg;
    logic                  done_reg;
    logic                  busy_reg;
    logic                  rd_pend_reg;
    logic [DATA_W_MAX-1:0] data_reg;
    logic [3:0]            nbits_reg;
    parity_mode_t          pmode_reg;
    logic                  two_stop_reg;
    logic                  big_end_reg;
    logic [3:0]            bit_cnt_reg;
    logic [STOP_W-1:0]     stop_cnt_reg;

    logic start_ok;
    logic last_bit;
    logic stop_last;
    logic launch;
    logic drive_bit;
    logic par_en;
    logic parity_bit;

    // Bit k of the frame in transmission order, honouring bit order and length.
    function automatic logic pick_bit(input logic [DATA_W_MAX-1:0] data,
                                      input logic [3:0] nbits,
                                      input logic big,
                                      input logic [3:0] k);
        logic [3:0]            idx;
        logic [DATA_W_MAX-1:0] sh;
        idx = big ? (nbits - 4'd1 - k) : k;
        sh  = data >> idx;
        return sh[0];
    endfunction

    // Frame-start conditions and the bit about to be driven on this tick.
    always_comb begin
        start_ok  = p_TxEn_i & ~p_FiFoEmpty_i & ~p_Break_i;
        last_bit  = (bit_cnt_reg == (nbits_reg - 4'd1));
        stop_last = (stop_cnt_reg == STOP_W'(two_stop_reg));
        launch    = p_BaudSig_i & start_ok &
                    ((state_reg == ST_IDLE) | ((state_reg == ST_STOP) & stop_last));
        drive_bit = (state_reg == ST_START)
                  ? pick_bit(data_reg, nbits_reg, big_end_reg, 4'd0)
                  : pick_bit(data_reg, nbits_reg, big_end_reg, bit_cnt_reg + 4'd1);
        par_en    = p_BaudSig_i &
                    ((state_reg == ST_START) | ((state_reg == ST_DATA) & ~last_bit));
    end

    uart_parity_acc u_parity (
        .clk    (clk),
        .rst    (rst),
        .clr    (launch),
        .en     (par_en),
        .bit_in (drive_bit),
        .mode   (pmode_reg),
        .parity (parity_bit)
    );

    // Transmit FSM with registered line, strobe, busy and done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            line_reg     <= 1'b1;
            re_n_reg     <= 1'b1;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            rd_pend_reg  <= 1'b0;
            data_reg     <= '0;
            nbits_reg    <= 4'd0;
            pmode_reg    <= PAR_NONE;
            two_stop_reg <= 1'b0;
            big_end_reg  <= 1'b0;
            bit_cnt_reg  <= 4'd0;
            stop_cnt_reg <= '0;
        end else begin
            re_n_reg    <= 1'b1;
            done_reg    <= 1'b0;
            // FIFO data is valid one clock after the strobe has been seen.
            rd_pend_reg <= ~re_n_reg;
            if (rd_pend_reg) begin
                data_reg <= FifoData_i;
            end
            if (p_BaudSig_i) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (p_Break_i) begin
                            state_reg <= ST_BREAK;
                            line_reg  <= 1'b0;
                            busy_reg  <= 1'b1;
                        end
                    end
                    ST_START: begin
                        state_reg   <= ST_DATA;
                        bit_cnt_reg <= 4'd0;
                        line_reg    <= drive_bit;
                    end
                    ST_DATA: begin
                        if (last_bit) begin
                            if (pmode_reg != PAR_NONE) begin
                                state_reg <= ST_PARITY;
                                line_reg  <= parity_bit;
                            end else begin
                                state_reg    <= ST_STOP;
                                line_reg     <= 1'b1;
                                stop_cnt_reg <= '0;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            line_reg    <= drive_bit;
                        end
                    end
                    ST_PARITY: begin
                        state_reg    <= ST_STOP;
                        line_reg     <= 1'b1;
                        stop_cnt_reg <= '0;
                    end
                    ST_STOP: begin
                        if (stop_last) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            line_reg  <= 1'b1;
                        end else begin
                            stop_cnt_reg <= stop_cnt_reg + 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        if (!p_Break_i) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            line_reg  <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        line_reg  <= 1'b1;
                    end
                endcase
            end
            // A new frame (from IDLE or straight after the last stop bit)
            // overrides the idle transition above and snapshots the config.
            if (launch) begin
                re_n_reg     <= 1'b0;
                state_reg    <= ST_START;
                line_reg     <= 1'b0;
                busy_reg     <= 1'b1;
                nbits_reg    <= eff_data_bits(DataBits_i, DATA_W_MAX);
                pmode_reg    <= norm_parity(ParityMode_i);
                two_stop_reg <= TwoStop_i;
                big_end_reg  <= p_BigEnd_i;
            end
        end
    end

    assign n_FifoRe_o   = re_n_reg;
    assign SerialData_o = line_reg;
    assign State_o      = state_reg;
    assign p_Busy_o     = busy_reg;
    assign p_Done_o     = done_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues hand-computed
// line bits, a monitor pops and compares one bit per busy baud tick.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud = 1'b0;
    logic       txen = 1'b0;
    logic [3:0] dbits = 4'd8;
    logic [2:0] pmode = 3'd0;
    logic       two = 1'b0;
    logic       big = 1'b0;
    logic       brk = 1'b0;
    logic [8:0] fdata = 9'd0;
    logic       fempty = 1'b1;
    logic       re_n;
    logic       line;
    logic [5:0] state;
    logic       busy;
    logic       done;

    bit         exp_q[$];
    logic [8:0] fifo_q[$];
    int         done_ticks[$];
    int         strobe_ticks[$];
    int         tests = 0;
    int         fails = 0;
    int         tick_cnt = 0;
    int         strobe_cnt = 0;
    int         done_cnt = 0;

    uart_tx_serializer #(.DATA_W_MAX(9), .STOP_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .p_BaudSig_i   (baud),
        .p_TxEn_i      (txen),
        .DataBits_i    (dbits),
        .ParityMode_i  (pmode),
        .TwoStop_i     (two),
        .p_BigEnd_i    (big),
        .p_Break_i     (brk),
        .n_FifoRe_o    (re_n),
        .FifoData_i    (fdata),
        .p_FiFoEmpty_i (fempty),
        .SerialData_o  (line),
        .State_o       (state),
        .p_Busy_o      (busy),
        .p_Done_o      (done)
    );

    always #5 clk = ~clk;

    // Baud tick: one clock high out of every eight.
    initial begin
        forever begin
            repeat (7) @(negedge clk);
            baud = 1'b1;
            @(negedge clk);
            baud = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, got);
        end
    endtask

    // Monitor: FIFO model, strobe/done counters and line-bit scoreboard.
    initial begin
        logic was_tick;
        logic re_prev;
        bit   e;
        re_prev = 1'b1;
        forever begin
            @(posedge clk);
            was_tick = baud;
            #1;
            if (was_tick) tick_cnt++;
            if (!re_prev) begin
                if (fifo_q.size() == 0) begin
                    check("fifo_underflow", 32'd1, 32'd0);
                end else begin
                    fdata = fifo_q.pop_front();
                end
            end
            fempty = (fifo_q.size() == 0);
            if (re_n === 1'b0) begin
                strobe_cnt++;
                strobe_ticks.push_back(tick_cnt);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_ticks.push_back(tick_cnt);
            end
            if (was_tick && busy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_busy_bit", {31'd0, line}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("line_bit_tick%0d", tick_cnt), {31'd0, line}, {31'd0, e});
                end
            end
            re_prev = re_n;
        end
    end

    task automatic push_exp(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(bits[i]);
    endtask

    task automatic wait_ticks(input int n);
        int t0;
        t0 = tick_cnt;
        while (tick_cnt < t0 + n) @(negedge clk);
    endtask

    task automatic wait_done(input int target, input int budget);
        int t0;
        t0 = tick_cnt;
        while (done_cnt < target && tick_cnt < t0 + budget) @(negedge clk);
        check("done_count", done_cnt, target);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic wait_databits();
        int n;
        n = 0;
        while (state !== 6'b000100 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("reach_databits", {26'd0, state}, 32'h04);
    endtask

    initial begin
        int d0;
        int s0;
        int nd;
        int ns;
        repeat (3) @(negedge clk);
        check("rst_line", {31'd0, line}, 32'd1);
        check("rst_re_n", {31'd0, re_n}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {26'd0, state}, 32'h01);
        rst = 1'b0;
        wait_ticks(2);

        // 0x55 8N1 LSB-first
        s0 = strobe_cnt; d0 = done_cnt;
        txen = 1'b1; dbits = 4'd8; pmode = 3'd0; two = 1'b0; big = 1'b0;
        push_exp(32'b0101010101, 10);
        fifo_q.push_back(9'h055);
        wait_done(d0 + 1, 40);
        check("s1_strobes", strobe_cnt - s0, 1);

        // 0x0A3, 7 bits, even parity, MSB-first
        s0 = strobe_cnt; d0 = done_cnt;
        dbits = 4'd7; pmode = 3'd2; big = 1'b1;
        push_exp(32'b0010001111, 10);
        fifo_q.push_back(9'h0A3);
        wait_done(d0 + 1, 40);
        check("s2_strobes", strobe_cnt - s0, 1);

        // two words back to back, 8O2
        s0 = strobe_cnt; d0 = done_cnt;
        dbits = 4'd8; pmode = 3'd1; two = 1'b1; big = 1'b0;
        push_exp(32'b010001111011, 12);
        push_exp(32'b000000000111, 12);
        fifo_q.push_back(9'h0F1);
        fifo_q.push_back(9'h100);
        wait_done(d0 + 2, 60);
        check("s3_strobes", strobe_cnt - s0, 2);
        nd = done_ticks.size();
        ns = strobe_ticks.size();
        if (nd >= 2 && ns >= 2) begin
            check("s3_frame1_ticks", done_ticks[nd-2] - strobe_ticks[ns-2], 12);
            check("s3_frame2_gapless", done_ticks[nd-1] - done_ticks[nd-2], 12);
        end else begin
            check("s3_event_count", nd, 2);
        end

        // width changed mid-frame only affects the next frame
        s0 = strobe_cnt; d0 = done_cnt;
        dbits = 4'd8; pmode = 3'd0; two = 1'b0; big = 1'b0;
        push_exp(32'b0110000111, 10);
        push_exp(32'b0110001, 7);
        fifo_q.push_back(9'h0C3);
        fifo_q.push_back(9'h0C3);
        wait_databits();
        dbits = 4'd5;
        wait_done(d0 + 2, 60);
        check("s4_strobes", strobe_cnt - s0, 2);

        // out-of-range width falls back to 8, mark parity
        d0 = done_cnt;
        dbits = 4'd12; pmode = 3'd3;
        push_exp(32'b01100001111, 11);
        fifo_q.push_back(9'h0C3);
        wait_done(d0 + 1, 40);

        // full 9-bit payload, space parity
        d0 = done_cnt;
        dbits = 4'd9; pmode = 3'd4;
        push_exp(32'b011111111101, 12);
        fifo_q.push_back(9'h1FF);
        wait_done(d0 + 1, 40);

        // undefined parity code 6 acts as none, 5 bits MSB-first
        d0 = done_cnt;
        dbits = 4'd5; pmode = 3'd6; big = 1'b1;
        push_exp(32'b0100111, 7);
        fifo_q.push_back(9'h013);
        wait_done(d0 + 1, 40);

        // break for 20 ticks with a word waiting but transmit disabled
        txen = 1'b0; big = 1'b0; dbits = 4'd8; pmode = 3'd0;
        fifo_q.push_back(9'h0AA);
        wait_ticks(1);
        s0 = strobe_cnt;
        brk = 1'b1;
        for (int i = 0; i < 20; i++) exp_q.push_back(1'b0);
        wait_ticks(20);
        brk = 1'b0;
        wait_ticks(1);
        check("brk_line_release", {31'd0, line}, 32'd1);
        check("brk_state_idle", {26'd0, state}, 32'h01);
        check("brk_no_read", strobe_cnt - s0, 0);
        check("brk_drained", exp_q.size(), 0);
        wait_ticks(1);
        check("brk_line_high_period", {31'd0, line}, 32'd1);
        fifo_q.delete();
        wait_ticks(2);

        // reset while data bit 3 is on the line
        d0 = done_cnt;
        txen = 1'b1;
        push_exp(32'b01010, 5);
        fifo_q.push_back(9'h0A5);
        wait_databits();
        wait_ticks(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_line", {31'd0, line}, 32'd1);
        check("mrst_state", {26'd0, state}, 32'h01);
        check("mrst_re_n", {31'd0, re_n}, 32'd1);
        s0 = strobe_cnt;
        wait_ticks(15);
        check("mrst_no_done", done_cnt - d0, 0);
        check("mrst_no_read", strobe_cnt - s0, 0);
        check("mrst_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
